// File: rtl/list_sum_engine_if.sv
// Handshake bundle for list_sum_engine: start/head control, memory read port, status.
// LIST_SUM_SAT_EN adds the sticky ovf output.
interface list_sum_engine_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 255
);
  localparam int CNT_W = $clog2(MAX_NODES + 1);

  logic              start;
  logic [ADDR_W-1:0] head;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] sum;
  logic [CNT_W-1:0]  node_count;
`ifdef LIST_SUM_SAT_EN
  logic              ovf;
`endif

  modport master (
    input  start, head, mem_ack, mem_rdata,
    output mem_req, mem_addr, busy, done,
    output err, sum, node_count
`ifdef LIST_SUM_SAT_EN
    , output ovf
`endif
  );

  modport slave (
    output start, head, mem_ack, mem_rdata,
    input  mem_req, mem_addr, busy, done,
    input  err, sum, node_count
`ifdef LIST_SUM_SAT_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/list_sum_engine.sv
// Linked-list walker summing node values over a req/ack word-read port.
// LIST_SUM_SAT_EN: saturating sum with sticky ovf; default wraps.
module list_sum_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 255
) (
  input logic clk,
  input logic rst,
  list_sum_engine_if.master bus
);
  localparam int CNT_W = $clog2(MAX_NODES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    RD_VAL  = 4'b0010,
    RD_NEXT = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  // Initialisers give the reset values from power-up.
  state_t            state    = IDLE;
  logic [ADDR_W-1:0] ptr      = '0;
  logic              mem_req  = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic              busy     = 1'b0;
  logic              done     = 1'b0;
  logic              err      = 1'b0;
  logic [DATA_W-1:0] sum      = '0;
  logic [CNT_W-1:0]  cnt      = '0;
  logic [ADDR_W-1:0] next_ptr;
  logic              xfer;

  assign next_ptr = bus.mem_rdata[ADDR_W-1:0];
  assign xfer     = mem_req & bus.mem_ack;

`ifdef LIST_SUM_SAT_EN
  logic              ovf = 1'b0;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sum_nxt;

  assign add_full = {1'b0, sum} + {1'b0, bus.mem_rdata};
  assign sum_nxt  = (add_full[DATA_W] | ovf) ? '1
                                             : add_full[DATA_W-1:0];
  assign bus.ovf  = ovf;
`else
  logic [DATA_W-1:0] sum_nxt;

  assign sum_nxt = sum + bus.mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sum      <= '0;
      cnt      <= '0;
`ifdef LIST_SUM_SAT_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sum <= '0;
            cnt <= '0;
            err <= 1'b0;
`ifdef LIST_SUM_SAT_EN
            ovf <= 1'b0;
`endif
            if (bus.head == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              ptr      <= bus.head;
              mem_addr <= bus.head;
              mem_req  <= 1'b1;
              busy     <= 1'b1;
              state    <= RD_VAL;
            end
          end
        end
        RD_VAL: begin
          if (xfer) begin
            sum      <= sum_nxt;
`ifdef LIST_SUM_SAT_EN
            ovf      <= ovf | add_full[DATA_W];
`endif
            cnt      <= cnt + 1'b1;
            mem_addr <= ptr + 1'b1;
            state    <= RD_NEXT;
          end
        end
        RD_NEXT: begin
          if (xfer) begin
            if (next_ptr == '0 || cnt == MAX_CNT) begin
              err     <= (next_ptr != '0);
              mem_req <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              ptr      <= next_ptr;
              mem_addr <= next_ptr;
              state    <= RD_VAL;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.sum        = sum;
  assign bus.node_count = cnt;
endmodule

// File: tb/tb_list_sum_engine.sv
// Directed bench for list_sum_engine: 32-bit instance plus an 8-bit
// instance for the overflow case (LIST_SUM_SAT_EN aware).
module tb_list_sum_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  list_sum_engine_if #(.DATA_W(32), .ADDR_W(8), .MAX_NODES(255)) m ();
  list_sum_engine #(.DATA_W(32), .ADDR_W(8), .MAX_NODES(255)) dut (
    .clk(clk), .rst(rst), .bus(m)
  );

  list_sum_engine_if #(.DATA_W(8), .ADDR_W(8), .MAX_NODES(255)) s ();
  list_sum_engine #(.DATA_W(8), .ADDR_W(8), .MAX_NODES(255)) dut8 (
    .clk(clk), .rst(rst), .bus(s)
  );

  logic [31:0] mem  [256];
  logic [7:0]  mem8 [256];
  logic        start  = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  head   = 8'h00;
  logic [7:0]  head8  = 8'h00;
  logic        mack   = 1'b0;
  logic        rack   = 1'b0;
  logic        rand_mode = 1'b0;
  int          dly    = 0;
  int          stab_err = 0;
  logic        pend   = 1'b0;
  logic [7:0]  paddr  = 8'h00;

  assign m.start     = start;
  assign m.head      = head;
  assign m.mem_ack   = rand_mode ? rack : mack;
  assign m.mem_rdata = mem[m.mem_addr];
  assign s.start     = start8;
  assign s.head      = head8;
  assign s.mem_ack   = 1'b1;
  assign s.mem_rdata = mem8[s.mem_addr];

  // Random-latency memory: 0-5 idle cycles before each ack.
  always @(negedge clk) begin
    if (rand_mode) begin
      if (pend && m.mem_req && m.mem_addr !== paddr) stab_err++;
      if (m.mem_req) begin
        if (dly == 0) begin
          rack = 1'b1;
          dly  = $urandom_range(5, 0);
        end else begin
          rack = 1'b0;
          dly--;
        end
      end else begin
        rack = 1'b0;
      end
      pend  = m.mem_req && !rack;
      paddr = m.mem_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({m.busy, m.done, m.err, m.mem_req, m.mem_addr,
         m.sum, m.node_count} !== 45'd0) begin
      failures++;
      $display("FAIL powerup_outputs actual=%0h expected=0",
               {m.busy, m.done, m.err, m.mem_req, m.mem_addr,
                m.sum, m.node_count});
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({m.busy, m.done, m.err, m.mem_req, m.mem_addr,
         m.sum, m.node_count} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%0h expected=0",
               {m.busy, m.done, m.err, m.mem_req, m.mem_addr,
                m.sum, m.node_count});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_list3;
    int n;
    mem[8'h10] = 32'd5;
    mem[8'h11] = 32'h20;
    mem[8'h20] = 32'd7;
    mem[8'h21] = 32'h30;
    mem[8'h30] = 32'd9;
    mem[8'h31] = 32'h0;
    mack  = 1'b1;
    head  = 8'h10;
    start = 1'b1;
    tick();
    n = 1;
    checks++;
    if (m.busy !== 1'b1 || m.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL list3_busy actual=%b%b expected=11",
               m.busy, m.mem_req);
    end
    while (!m.done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL list3_latency actual=%0d expected=7", n);
    end
    checks++;
    if (m.sum !== 32'd21) begin
      failures++;
      $display("FAIL list3_sum actual=%0d expected=21", m.sum);
    end
    checks++;
    if (m.node_count !== 8'd3 || m.err !== 1'b0) begin
      failures++;
      $display("FAIL list3_count_err actual=%0d/%b expected=3/0",
               m.node_count, m.err);
    end
    tick();
    checks++;
    if ({m.done, m.busy, m.mem_req} !== 3'b100) begin
      failures++;
      $display("FAIL done_hold actual=%b expected=100",
               {m.done, m.busy, m.mem_req});
    end
    start = 1'b0;
    tick();
    checks++;
    if (m.done !== 1'b0 || m.sum !== 32'd21 || m.node_count !== 8'd3) begin
      failures++;
      $display("FAIL idle_hold actual=%b/%0d/%0d expected=0/21/3",
               m.done, m.sum, m.node_count);
    end
  endtask

  task automatic test_empty;
    head  = 8'h00;
    start = 1'b1;
    tick();
    checks++;
    if (m.done !== 1'b1 || m.mem_req !== 1'b0 || m.busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_done actual=%b%b%b expected=100",
               m.done, m.mem_req, m.busy);
    end
    checks++;
    if (m.sum !== 32'd0 || m.node_count !== 8'd0) begin
      failures++;
      $display("FAIL empty_clear actual=%0d/%0d expected=0/0",
               m.sum, m.node_count);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_self_loop;
    int n;
    mem[8'h04] = 32'd1;
    mem[8'h05] = 32'h04;
    mack  = 1'b1;
    head  = 8'h04;
    start = 1'b1;
    tick();
    n = 1;
    while (!m.done && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 511) begin
      failures++;
      $display("FAIL loop_latency actual=%0d expected=511", n);
    end
    checks++;
    if (m.err !== 1'b1) begin
      failures++;
      $display("FAIL loop_err actual=%b expected=1", m.err);
    end
    checks++;
    if (m.sum !== 32'd255 || m.node_count !== 8'd255) begin
      failures++;
      $display("FAIL loop_sum_count actual=%0d/%0d expected=255/255",
               m.sum, m.node_count);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_random_ack;
    int n;
    rand_mode = 1'b1;
    head  = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    head  = 8'h30;
    n = 1;
    while (!m.done && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (m.done !== 1'b1) begin
      failures++;
      $display("FAIL rand_timeout actual=%b expected=1", m.done);
    end
    checks++;
    if (m.sum !== 32'd21 || m.node_count !== 8'd3 || m.err !== 1'b0) begin
      failures++;
      $display("FAIL rand_result actual=%0d/%0d/%b expected=21/3/0",
               m.sum, m.node_count, m.err);
    end
    checks++;
    if (stab_err !== 0) begin
      failures++;
      $display("FAIL rand_addr_stable actual=%0d expected=0", stab_err);
    end
    rand_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    mack  = 1'b0;
    head  = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== 8'h10) begin
      failures++;
      $display("FAIL mid_val_req actual=%b/%0h expected=1/10",
               m.mem_req, m.mem_addr);
    end
    mack = 1'b1;
    tick();
    mack = 1'b0;
    tick();
    tick();
    checks++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== 8'h11 || m.sum !== 32'd5) begin
      failures++;
      $display("FAIL mid_next_hold actual=%b/%0h/%0d expected=1/11/5",
               m.mem_req, m.mem_addr, m.sum);
    end
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mack = 1'b1;
    tick();
    tick();
    checks++;
    if ({m.busy, m.done, m.err, m.mem_req, m.mem_addr,
         m.sum, m.node_count} !== 45'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs actual=%0h expected=0",
               {m.busy, m.done, m.err, m.mem_req, m.mem_addr,
                m.sum, m.node_count});
    end
    mack = 1'b0;
  endtask

  task automatic test_overflow;
    int n;
    mem8[8'h10] = 8'd200;
    mem8[8'h11] = 8'h20;
    mem8[8'h20] = 8'd100;
    mem8[8'h21] = 8'h00;
    head8  = 8'h10;
    start8 = 1'b1;
    tick();
    n = 1;
    while (!s.done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || s.node_count !== 8'd2) begin
      failures++;
      $display("FAIL ovf_latency_count actual=%0d/%0d expected=5/2",
               n, s.node_count);
    end
`ifdef LIST_SUM_SAT_EN
    checks++;
    if (s.sum !== 8'd255 || s.ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_sum actual=%0d/%b expected=255/1", s.sum, s.ovf);
    end
`else
    checks++;
    if (s.sum !== 8'd44) begin
      failures++;
      $display("FAIL wrap_sum actual=%0d expected=44", s.sum);
    end
`endif
    start8 = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'd0;
      mem8[i] = 8'd0;
    end
    test_reset();
    test_list3();
    test_empty();
    test_self_loop();
    test_random_ack();
    test_reset_mid();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/list_sum_engine.md
LIST_SUM_ENGINE -- requirements
Module: list_sum_engine

Interface
REQ-001 Parameter: DATA_W, 32, width of node value, pointer-extended data bus and sum.
REQ-002 Parameter: ADDR_W, 8, memory word-address width; 2 <= ADDR_W <= DATA_W.
REQ-003 Parameter: MAX_NODES, 255, node limit before loop error; 1 <= MAX_NODES <= 2^ADDR_W - 1.
REQ-004 Port: clk  in  1  clock, all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: start  in  1  level request to traverse list; sampled only in IDLE and DONE.
REQ-007 Port: head  in  ADDR_W  first node address, sampled on the accepting edge.
REQ-008 Port: mem_req  out  1  read request, held until acknowledged.
REQ-009 Port: mem_addr  out  ADDR_W  read word address, stable while mem_req=1.
REQ-010 Port: mem_ack  in  1  read complete; mem_rdata valid in the same cycle; ignored while mem_req=0.
REQ-011 Port: mem_rdata  in  DATA_W  read data.
REQ-012 Port: busy  out  1  traversal in progress.
REQ-013 Port: done  out  1  result valid.
REQ-014 Port: err  out  1  traversal aborted at MAX_NODES.
REQ-015 Port: sum  out  DATA_W  accumulated node values.
REQ-016 Port: node_count  out  $clog2(MAX_NODES+1)  nodes summed.

Function
REQ-017 Memory layout: node at address a holds value at word a and next pointer at word a+1 (low ADDR_W bits of mem_rdata); a+1 wraps modulo 2^ADDR_W; pointer 0 terminates the list.
REQ-018 States: IDLE, RD_VAL, RD_NEXT, DONE; one-hot encoded; unreachable encodings return to IDLE on the next edge.
REQ-019 IDLE: busy=0, done=0, mem_req=0; on start=1 clear sum, node_count and err; head=0 -> DONE, else latch ptr=head -> RD_VAL.
REQ-020 RD_VAL: mem_req=1, mem_addr=ptr; on mem_req&mem_ack: sum <= sum+mem_rdata, node_count+1 -> RD_NEXT.
REQ-021 RD_NEXT: mem_req=1, mem_addr=ptr+1; on ack: next=0 -> DONE; next!=0 and node_count=MAX_NODES -> DONE with err=1; otherwise ptr<=next -> RD_VAL.
REQ-022 Without ack, the state, mem_addr and mem_req hold indefinitely; ack may arrive in the same cycle mem_req rises (zero-wait memory).
REQ-023 Latency with mem_ack tied 1: N-node list reaches done 1+2N edges after the accepting edge; empty list 1 edge.
REQ-024 DONE: done=1, busy=0, mem_req=0; hold while start=1; start=0 -> IDLE; a new traversal therefore requires start to be deasserted then reasserted.
REQ-025 start changes while busy are ignored; head is not resampled mid-traversal.
REQ-026 sum wraps modulo 2^DATA_W unless REQ-032 applies; sum, node_count and err hold their values through DONE and IDLE until the next accepting edge.
REQ-027 busy=1 exactly in RD_VAL and RD_NEXT; done and busy are never both 1.

Reset
REQ-028 rst=1 on an edge forces IDLE, mem_req=0, mem_addr=0, busy=0, done=0, err=0, sum=0, node_count=0, with priority over all other inputs.
REQ-029 Reset mid-traversal abandons any outstanding read; an ack arriving after reset is ignored.
REQ-030 All outputs carry the REQ-028 values from power-up initialisation.

Configuration
REQ-031 Macro LIST_SUM_SAT_EN selects overflow handling.
REQ-032 LIST_SUM_SAT_EN defined: an addition carrying out of DATA_W clamps sum to all-ones and sets sticky output ovf (1 bit, reset/start clears it); defined: further additions keep all-ones.
REQ-033 LIST_SUM_SAT_EN undefined: sum wraps and ovf is not present on the port list.

Verification
REQ-034 mem_ack=1; nodes 0x10:(5,0x20), 0x20:(7,0x30), 0x30:(9,0) -> sum=21, node_count=3, done 7 edges after the accepting edge, err=0.
REQ-035 head=0, start=1 -> no mem_req, done=1 one edge later, sum=0, node_count=0.
REQ-036 Self-loop 0x04:(1,0x04), MAX_NODES=255 -> done=1, err=1, sum=255, node_count=255.
REQ-037 Random ack delays 0-5 cycles on REQ-034 list -> same result; mem_addr stable during every pending req.
REQ-038 rst pulsed while in RD_NEXT, then late ack -> IDLE, all outputs zero, no state change from ack.
REQ-039 DATA_W=8, values 200 and 100 -> with LIST_SUM_SAT_EN sum=255, ovf=1; without it sum=44.
